// File: rtl/armleocpu_cache_port_arbiter.sv
// Arbiter sharing one cache command port between fetch (F) and data/memory stage (D).
// D normally wins a simultaneous request; F is forced through after STARVE_LIMIT lost rounds.
// The grant is combinational and is held until c_done.
// Optional macro ARMLEOCPU_CACHE_ARB_PROTOCOL_CHECK_EN enables the sticky proto_err checker.
module armleocpu_cache_port_arbiter #(
    parameter logic [3:0] STARVE_LIMIT = 4'd15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [3:0]  f_cmd,
    input  logic [31:0] f_address,
    output logic        f_done,
    output logic [3:0]  f_response,
    output logic [31:0] f_load_data,

    input  logic [3:0]  d_cmd,
    input  logic [31:0] d_address,
    input  logic [31:0] d_store_data,
    output logic        d_done,
    output logic [3:0]  d_response,
    output logic [31:0] d_load_data,

    output logic [3:0]  c_cmd,
    output logic [31:0] c_address,
    output logic [31:0] c_store_data,
    input  logic        c_done,
    input  logic [3:0]  c_response,
    input  logic [31:0] c_load_data,

    output logic        owner,
    output logic        busy,
    output logic        proto_err
);

    localparam logic [3:0] CACHE_CMD_NONE = 4'd0;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic f_req, d_req;
    logic hold;       // BUSY without c_done: current owner keeps the port
    logic grant_pt;   // IDLE, or BUSY with c_done
    logic win_valid;
    logic win_d;      // winner of this grant point is D
    logic sel_d;      // D drives the cache port this cycle
    logic done_pt;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Winner selection, next state and starvation counter
    always_comb begin
        f_req     = (f_cmd != CACHE_CMD_NONE);
        d_req     = (d_cmd != CACHE_CMD_NONE);
        hold      = (state_q == StBusy) && !c_done;
        grant_pt  = !hold;
        win_valid = f_req || d_req;
        win_d     = d_req && !(f_req && (starve_cnt_q == STARVE_LIMIT));
        sel_d     = hold ? owner_q : win_d;
        done_pt   = (state_q == StBusy) && c_done;

        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        if (grant_pt) begin
            state_d = win_valid ? StBusy : StIdle;
            if (win_valid) begin
                owner_d = win_d;
                if (!win_d) begin
                    starve_cnt_d = 4'd0;
                end else if (f_req && (starve_cnt_q != STARVE_LIMIT)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
        end
    end

`ifdef ARMLEOCPU_CACHE_ARB_PROTOCOL_CHECK_EN
    logic        proto_err_q, proto_err_d;
    logic [3:0]  hold_cmd_q, hold_cmd_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [3:0]  own_cmd;
    logic [31:0] own_addr;

    // Checker state: sticky error flag and the command captured at grant
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
            hold_cmd_q  <= CACHE_CMD_NONE;
            hold_addr_q <= 32'd0;
        end else begin
            proto_err_q <= proto_err_d;
            hold_cmd_q  <= hold_cmd_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    // Flag owner instability while BUSY and c_done arriving while IDLE
    always_comb begin
        proto_err_d = proto_err_q;
        hold_cmd_d  = hold_cmd_q;
        hold_addr_d = hold_addr_q;
        own_cmd     = owner_q ? d_cmd : f_cmd;
        own_addr    = owner_q ? d_address : f_address;
        if (hold && ((own_cmd != hold_cmd_q) || (own_addr != hold_addr_q)
                     || (own_cmd == CACHE_CMD_NONE))) begin
            proto_err_d = 1'b1;
        end
        if ((state_q == StIdle) && c_done) begin
            proto_err_d = 1'b1;
        end
        if (grant_pt && win_valid) begin
            hold_cmd_d  = win_d ? d_cmd : f_cmd;
            hold_addr_d = win_d ? d_address : f_address;
        end
    end
`endif

    // Port muxing, done routing and status outputs; everything forced to 0 during rst
    always_comb begin
        c_cmd        = CACHE_CMD_NONE;
        c_address    = 32'd0;
        c_store_data = 32'd0;
        f_done       = 1'b0;
        f_response   = 4'd0;
        f_load_data  = 32'd0;
        d_done       = 1'b0;
        d_response   = 4'd0;
        d_load_data  = 32'd0;

        if (hold || win_valid) begin
            if (sel_d) begin
                c_cmd        = d_cmd;
                c_address    = d_address;
                c_store_data = d_store_data;
            end else begin
                c_cmd     = f_cmd;
                c_address = f_address;
            end
        end

        if (done_pt) begin
            if (owner_q) begin
                d_done      = 1'b1;
                d_response  = c_response;
                d_load_data = c_load_data;
            end else begin
                f_done      = 1'b1;
                f_response  = c_response;
                f_load_data = c_load_data;
            end
        end

        busy  = (state_q == StBusy);
        owner = owner_q;
`ifdef ARMLEOCPU_CACHE_ARB_PROTOCOL_CHECK_EN
        proto_err = proto_err_q;
`else
        proto_err = 1'b0;
`endif

        if (rst) begin
            c_cmd        = CACHE_CMD_NONE;
            c_address    = 32'd0;
            c_store_data = 32'd0;
            f_done       = 1'b0;
            f_response   = 4'd0;
            f_load_data  = 32'd0;
            d_done       = 1'b0;
            d_response   = 4'd0;
            d_load_data  = 32'd0;
            busy         = 1'b0;
            owner        = 1'b0;
            proto_err    = 1'b0;
        end
    end

endmodule
